// File: rtl/vx_operands_arb_pkg.sv
// Shared constants and helpers for the operands arbiter.
// The payload itself is opaque to this block; only its width (DATAW) is
// passed in, so nothing payload-specific lives here.
package vx_operands_arb_pkg;

  // Depth of the registered output buffer behind the arbiter.
  localparam int unsigned BUF_DEPTH = 2;

  // Round-robin candidate index: `offset` positions after `base`, modulo `n`.
  function automatic int unsigned rr_index(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/vx_operands_arb_buf.sv
// Two-entry registered FIFO that decouples downstream ready from the
// arbiter's input-side ready.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   push_i        - write push_data_i at the tail (only when space_o)
//   push_data_i   - entry to write
//   pop_i         - drop the head entry (only when valid_o)
//   space_o       - fewer than BUF_DEPTH entries held
//   valid_o       - at least one entry held
//   head_o        - oldest entry
module vx_operands_arb_buf
  import vx_operands_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             space_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  logic [1:0]       count_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;

  assign space_o = (count_q != FULL_CNT);
  assign valid_o = (count_q != 2'd0);
  assign head_o  = head_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data_i;
          else                 tail_q <= push_data_i;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        // Push is gated by space, so a simultaneous push/pop only happens
        // with a single entry held: the new entry becomes the head.
        2'b11: head_q <= push_data_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/vx_operands_arb.sv
// Round-robin arbiter merging NUM_INPUTS operand-collector channels onto one
// dispatch channel, with a 2-entry output buffer and a saturating stall
// counter for the perf subsystem.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   in_valid     - per-channel valid
//   in_data      - per-channel payload, channel i at [i*DATAW +: DATAW]
//   in_ready     - per-channel ready (at most one bit high)
//   out_valid    - head entry valid
//   out_data     - head payload
//   out_sel      - source channel of the head entry
//   out_ready    - downstream accept
//   perf_stalls  - saturating count of cycles with a request but no space
module vx_operands_arb
  import vx_operands_arb_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned DATAW      = 64,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_INPUTS-1:0]         in_valid,
  input  logic [NUM_INPUTS*DATAW-1:0]   in_data,
  output logic [NUM_INPUTS-1:0]         in_ready,
  output logic                          out_valid,
  output logic [DATAW-1:0]              out_data,
  output logic [$clog2(NUM_INPUTS)-1:0] out_sel,
  input  logic                          out_ready,
  output logic [PERF_W-1:0]             perf_stalls
);

  localparam int unsigned SEL_W = $clog2(NUM_INPUTS);

  logic [SEL_W-1:0]      last_q;
  logic [NUM_INPUTS-1:0] grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [DATAW-1:0]      grant_data;
  logic                  space;
  logic                  push;
  logic                  pop;
  logic [PERF_W-1:0]     stalls_q;

  // Scan from last+1 upward; the first valid channel wins.
  always_comb begin
    int unsigned idx;
    idx        = 0;
    grant      = '0;
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
      idx = rr_index(32'(last_q), k, NUM_INPUTS);
      if ((grant == '0) && in_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = SEL_W'(idx);
        grant_data = in_data[idx*DATAW +: DATAW];
      end
    end
  end

  // Ready depends only on in_valid and registered state, never on out_ready.
  assign in_ready = grant & {NUM_INPUTS{space}};
  assign push     = (|grant) & space;
  assign pop      = out_valid & out_ready;

  vx_operands_arb_buf #(
    .WIDTH (DATAW + SEL_W)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i ({grant_data, grant_idx}),
    .pop_i       (pop),
    .space_o     (space),
    .valid_o     (out_valid),
    .head_o      ({out_data, out_sel})
  );

  // last resets to NUM_INPUTS-1 so channel 0 has first priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q   <= SEL_W'(NUM_INPUTS - 1);
      stalls_q <= '0;
    end else begin
      if (push) last_q <= grant_idx;
      if ((|in_valid) && !space && (stalls_q != '1))
        stalls_q <= stalls_q + PERF_W'(1);
    end
  end

  assign perf_stalls = stalls_q;

endmodule

// File: tb/tb_vx_operands_arb.sv
module tb_vx_operands_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 4;

  logic              clk;
  logic              reset_n;
  logic [N-1:0]      in_valid;
  logic [N*DW-1:0]   in_data;
  logic [N-1:0]      in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_sel;
  logic              out_ready;
  logic [PW-1:0]     perf_stalls;

  int n_total = 0;
  int n_pass  = 0;

  vx_operands_arb #(
    .NUM_INPUTS (N),
    .DATAW      (DW),
    .PERF_W     (PW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_ready   (out_ready),
    .perf_stalls (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    in_data[i*DW +: DW] = v;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_sel", 64'(out_sel), 64'h0);
    chk("rst_perf", 64'(perf_stalls), 64'h0);
    #10;
    reset_n = 1'b1;
    next_cycle();

    // Single source on input 2
    in_valid  = 4'b0100;
    set_data(2, 32'h0000_0011);
    out_ready = 1'b1;
    settle();
    chk("single_in_ready", 64'(in_ready), 64'h4);
    chk("single_c0_out_valid", 64'(out_valid), 64'h0);
    next_cycle();
    in_valid = '0;
    settle();
    chk("single_out_valid", 64'(out_valid), 64'h1);
    chk("single_out_data", 64'(out_data), 64'h11);
    chk("single_out_sel", 64'(out_sel), 64'h2);
    next_cycle();
    settle();
    chk("single_drained", 64'(out_valid), 64'h0);

    // Round-robin fairness, all valid, out_ready held high
    pulse_reset();
    for (int i = 0; i < N; i++) set_data(i, 32'hA0 + 32'(i));
    in_valid  = 4'hF;
    out_ready = 1'b1;
    settle();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("rr_in_ready_%0d", k), 64'(in_ready), 64'(1 << (k % 4)));
      if (k > 0) begin
        chk($sformatf("rr_out_valid_%0d", k), 64'(out_valid), 64'h1);
        chk($sformatf("rr_out_sel_%0d", k), 64'(out_sel), 64'((k - 1) % 4));
        chk($sformatf("rr_out_data_%0d", k), 64'(out_data), 64'(32'hA0 + 32'((k - 1) % 4)));
      end else begin
        chk("rr_out_valid_0", 64'(out_valid), 64'h0);
      end
      next_cycle();
      settle();
    end

    // Backpressure and stall-counter saturation
    pulse_reset();
    for (int i = 0; i < N; i++) set_data(i, 32'hB0 + 32'(i));
    in_valid  = 4'hF;
    out_ready = 1'b0;
    settle();
    for (int k = 0; k < 25; k++) begin
      int exp_ready;
      int exp_perf;
      exp_ready = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
      exp_perf  = (k < 2) ? 0 : (((k - 2) > 15) ? 15 : (k - 2));
      chk($sformatf("bp_in_ready_%0d", k), 64'(in_ready), 64'(exp_ready));
      chk($sformatf("bp_perf_%0d", k), 64'(perf_stalls), 64'(exp_perf));
      if (k >= 1) begin
        chk($sformatf("bp_head_sel_%0d", k), 64'(out_sel), 64'h0);
        chk($sformatf("bp_head_data_%0d", k), 64'(out_data), 64'hB0);
      end
      next_cycle();
      settle();
    end
    chk("sat_perf_hold", 64'(perf_stalls), 64'hF);

    // Pop from full: space only appears the following cycle
    out_ready = 1'b1;
    settle();
    chk("full_pop_in_ready", 64'(in_ready), 64'h0);
    next_cycle();
    settle();
    chk("after_pop_in_ready", 64'(in_ready), 64'h4);
    chk("after_pop_sel", 64'(out_sel), 64'h1);
    chk("after_pop_data", 64'(out_data), 64'hB1);
    chk("after_pop_perf", 64'(perf_stalls), 64'hF);

    // Simultaneous push and pop at count 1
    in_valid = 4'b1000;
    settle();
    chk("pp_in_ready_0", 64'(in_ready), 64'h8);
    next_cycle();
    set_data(3, 32'hC3);
    settle();
    chk("pp_in_ready_1", 64'(in_ready), 64'h8);
    chk("pp_sel_1", 64'(out_sel), 64'h3);
    chk("pp_data_1", 64'(out_data), 64'hB3);
    next_cycle();
    in_valid = '0;
    settle();
    chk("pp_valid_2", 64'(out_valid), 64'h1);
    chk("pp_sel_2", 64'(out_sel), 64'h3);
    chk("pp_data_2", 64'(out_data), 64'hC3);
    next_cycle();
    settle();
    chk("pp_drained", 64'(out_valid), 64'h0);

    // Reset mid-flight with a full buffer
    pulse_reset();
    set_data(0, 32'hD0);
    set_data(3, 32'hD3);
    in_valid  = 4'b1001;
    out_ready = 1'b0;
    settle();
    next_cycle();
    next_cycle();
    settle();
    chk("mid_full_valid", 64'(out_valid), 64'h1);
    chk("mid_full_in_ready", 64'(in_ready), 64'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_out_sel", 64'(out_sel), 64'h0);
    chk("mid_rst_perf", 64'(perf_stalls), 64'h0);
    reset_n = 1'b1;
    settle();
    chk("mid_rel_in_ready", 64'(in_ready), 64'h1);
    next_cycle();
    settle();
    chk("mid_rel_out_sel", 64'(out_sel), 64'h0);
    chk("mid_rel_out_data", 64'(out_data), 64'hD0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
